// File: rtl/circle_ctrl.sv
// circle_ctrl: sequencing FSM for the midpoint-circle datapath.
//
// Draws NUM_CIRCLES circles into a SCREEN_W x SCREEN_H framebuffer.
// When CLEAR_EN is set, it first sweeps the whole screen in black.
// For each circle it then runs: load circle index, init vars,
// and a loop of {check, 8-octant plot, Bresenham step}.
//
// Ports:
//   clock, resetb        system clock, async active-low reset
//   start                level request; sampled only in IDLE and DONE
//   crit_condition       datapath: crit <= 0
//   offset_condition     datapath: offsety <= offsetx
//   circle_num[2:0]      datapath: current circle index (1-based)
//   init_circle          select circle index 1 on next load_circle
//   load_circle          register next circle index
//   init_vars            select offsetx=r, offsety=0, crit=1-r
//   load_crit/offsetx/offsety   datapath register enables
//   pixel[3:0]           octant select 1..8 while plotting, else 0
//   plot                 VGA write strobe
//   clear_sel            VGA x/y/colour from clr_x/clr_y/black
//   clr_x[7:0], clr_y[6:0]      clear-phase coordinates
//   busy                 high in every state except IDLE and DONE
//   done                 high in DONE
module circle_ctrl #(
  parameter int NUM_CIRCLES = 5,
  parameter bit CLEAR_EN    = 1'b1,
  parameter int SCREEN_W    = 160,
  parameter int SCREEN_H    = 120
) (
  input  logic       clock,
  input  logic       resetb,
  input  logic       start,
  input  logic       crit_condition,
  input  logic       offset_condition,
  input  logic [2:0] circle_num,
  output logic       init_circle,
  output logic       load_circle,
  output logic       init_vars,
  output logic       load_crit,
  output logic       load_offsetx,
  output logic       load_offsety,
  output logic [3:0] pixel,
  output logic       plot,
  output logic       clear_sel,
  output logic [7:0] clr_x,
  output logic [6:0] clr_y,
  output logic       busy,
  output logic       done
);

  typedef enum logic [3:0] {
    S_IDLE        = 4'd0,
    S_CLEAR       = 4'd1,
    S_INIT_CIRCLE = 4'd2,
    S_INIT_VARS   = 4'd3,
    S_CHECK       = 4'd4,
    S_PLOT        = 4'd5,
    S_STEP        = 4'd6,
    S_NEXT_CIRCLE = 4'd7,
    S_DONE        = 4'd8
  } state_t;

  localparam logic [7:0] X_LAST    = 8'(SCREEN_W - 1);
  localparam logic [6:0] Y_LAST    = 7'(SCREEN_H - 1);
  localparam logic [2:0] LAST_CIRC = 3'(NUM_CIRCLES);

  state_t state;

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state <= S_IDLE;
      pixel <= 4'd0;
      clr_x <= 8'd0;
      clr_y <= 7'd0;
    end else begin
      case (state)
        S_IDLE: begin
          clr_x <= 8'd0;
          clr_y <= 7'd0;
          pixel <= 4'd0;
          if (start) state <= CLEAR_EN ? S_CLEAR : S_INIT_CIRCLE;
        end
        S_CLEAR: begin
          // Raster sweep: x fastest, leave after the bottom-right pixel.
          if (clr_x == X_LAST) begin
            clr_x <= 8'd0;
            if (clr_y == Y_LAST) begin
              clr_y <= 7'd0;
              state <= S_INIT_CIRCLE;
            end else begin
              clr_y <= clr_y + 7'd1;
            end
          end else begin
            clr_x <= clr_x + 8'd1;
          end
        end
        S_INIT_CIRCLE: state <= S_INIT_VARS;
        S_INIT_VARS:   state <= S_CHECK;
        S_CHECK: begin
          if (offset_condition) begin
            pixel <= 4'd1;
            state <= S_PLOT;
          end else begin
            state <= S_NEXT_CIRCLE;
          end
        end
        S_PLOT: begin
          if (pixel == 4'd8) begin
            pixel <= 4'd0;
            state <= S_STEP;
          end else begin
            pixel <= pixel + 4'd1;
          end
        end
        S_STEP: state <= S_CHECK;
        S_NEXT_CIRCLE: begin
          state <= (circle_num == LAST_CIRC) ? S_DONE : S_INIT_VARS;
        end
        S_DONE: begin
          // Wait for start to drop so a held request cannot retrigger.
          if (!start) state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          pixel <= 4'd0;
          clr_x <= 8'd0;
          clr_y <= 7'd0;
        end
      endcase
    end
  end

  // NOTE: every output is given a default before the case so no path
  // leaves one unassigned, which would infer a latch.
  always_comb begin
    init_circle  = 1'b0;
    load_circle  = 1'b0;
    init_vars    = 1'b0;
    load_crit    = 1'b0;
    load_offsetx = 1'b0;
    load_offsety = 1'b0;
    plot         = 1'b0;
    clear_sel    = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    case (state)
      S_IDLE: busy = 1'b0;
      S_CLEAR: begin
        plot      = 1'b1;
        clear_sel = 1'b1;
      end
      S_INIT_CIRCLE: begin
        init_circle = 1'b1;
        load_circle = 1'b1;
      end
      S_INIT_VARS: begin
        init_vars    = 1'b1;
        load_crit    = 1'b1;
        load_offsetx = 1'b1;
        load_offsety = 1'b1;
      end
      S_PLOT: plot = 1'b1;
      S_STEP: begin
        // x only moves inward when the midpoint lies outside (crit > 0).
        load_crit    = 1'b1;
        load_offsety = 1'b1;
        load_offsetx = ~crit_condition;
      end
      S_NEXT_CIRCLE: load_circle = (circle_num != LAST_CIRC);
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      S_CHECK: ;
      default: busy = 1'b0;
    endcase
  end

endmodule
